// File: rtl/re_demapper_pkg.sv
// Shared definitions for the PUSCH resource-element demapper: FSM encoding,
// grid geometry and allocation limits.
package re_demapper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_WAIT_SYM  = 3'd2,
    ST_READ_DMRS = 3'd3,
    ST_READ_DATA = 3'd4
  } state_e;

  localparam int TOTAL_SC_DEF = 1200;  // subcarriers per grid symbol row
  localparam int MAX_RB       = 100;   // largest legal allocation
  localparam int RE_PER_RB    = 12;    // data REs per RB per symbol
  localparam int DMRS_PER_RB  = 6;     // even-offset DMRS REs per RB

  // One past the last allocated subcarrier, in 12 bits so it cannot wrap.
  function automatic logic [11:0] alloc_end(input logic [10:0] n_sc,
                                            input logic [6:0]  n_rb);
    return {1'b0, n_sc} + 12'(n_rb) * 12'(RE_PER_RB);
  endfunction

endpackage

// File: rtl/re_demapper_sym_credit.sv
// Counts grid symbols that the mapper has finished but the demapper has not
// yet read. Saturates at 15 and never goes below 0.
module re_sym_credit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] credit
);

  logic [3:0] credit_d, credit_q;

  // Next credit value: clear wins, simultaneous inc/dec cancel out.
  always_comb begin
    credit_d = credit_q;
    if (clr) begin
      credit_d = 4'd0;
    end else if (inc && !dec) begin
      if (credit_q != 4'd15) credit_d = credit_q + 4'd1;
    end else if (dec && !inc) begin
      if (credit_q != 4'd0) credit_d = credit_q - 4'd1;
    end
  end

  // Credit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) credit_q <= 4'd0;
    else     credit_q <= credit_d;
  end

  assign credit = credit_q;

endmodule

// File: rtl/re_demapper.sv
// Reads one PUSCH allocation out of the resource grid, symbol by symbol:
// even-offset DMRS REs on Sym_Start, every allocated RE on the symbols after
// it up to Sym_End. A symbol is read only once the mapper has reported it
// complete (Sym_Ready credit).
//
// Handshake: there is no back-pressure. Grid_Rd_En is a read strobe; the grid
// returns Grid_I/Grid_Q exactly one cycle later, and that same cycle the
// matching *_Valid is high with its address/symbol tags. Everything an output
// carries is forced to 0 whenever its valid is low.
module re_demapper
  import re_demapper_pkg::*;
#(
  parameter int DATA_W   = 18,
  parameter int TOTAL_SC = TOTAL_SC_DEF
) (
  input  logic                     CLK_RE,
  input  logic                     RST_RE,
  input  logic                     Start,
  input  logic [10:0]              N_sc,
  input  logic [6:0]               N_rb,
  input  logic [3:0]               Sym_Start,
  input  logic [3:0]               Sym_End,
  input  logic                     Sym_Ready,
  output logic                     Grid_Rd_En,
  output logic [14:0]              Grid_Rd_Addr,
  input  logic signed [DATA_W-1:0] Grid_I,
  input  logic signed [DATA_W-1:0] Grid_Q,
  output logic signed [DATA_W-1:0] Dmrs_I,
  output logic signed [DATA_W-1:0] Dmrs_Q,
  output logic                     Dmrs_Valid,
  output logic [9:0]               Dmrs_Addr,
  output logic signed [DATA_W-1:0] Data_I,
  output logic signed [DATA_W-1:0] Data_Q,
  output logic                     Data_Valid,
  output logic [10:0]              Data_Addr,
  output logic [3:0]               Data_Sym,
  output logic                     Sym_Done,
  output logic                     Demap_Done,
  output logic                     Cfg_Err,
  output logic [2:0]               dbg_state,
  output logic [3:0]               dbg_credit
);

  // Control state
  state_e      state_d, state_q;
  logic [10:0] nsc_d, nsc_q;
  logic [6:0]  nrb_d, nrb_q;
  logic [3:0]  ss_d, ss_q;
  logic [3:0]  se_d, se_q;
  logic [3:0]  sym_d, sym_q;      // symbol currently being read / waited for
  logic [10:0] sc_d, sc_q;        // subcarrier of the read being issued
  logic [10:0] idx_d, idx_q;      // RE index of the read being issued
  logic        rd_en_d, rd_en_q;
  logic        cfg_err_d, cfg_err_q;

  // Return-path pipeline, aligned with the grid read latency
  logic        dmrs_v_d, dmrs_v_q;
  logic        data_v_d, data_v_q;
  logic [10:0] out_idx_d, out_idx_q;
  logic [3:0]  out_sym_d, out_sym_q;
  logic        sym_done_d, sym_done_q;
  logic        demap_done_d, demap_done_q;

  logic        credit_clr;
  logic [3:0]  credit;
  logic        is_dmrs;
  logic [10:0] n_re;
  logic        last_rd;
  logic [4:0]  sym_nxt;
  logic        sym_over;
  logic        cfg_bad;

  assign is_dmrs  = (state_q == ST_READ_DMRS);
  assign n_re     = is_dmrs ? 11'(nrb_q) * 11'(DMRS_PER_RB)
                            : 11'(nrb_q) * 11'(RE_PER_RB);
  assign last_rd  = rd_en_q && (idx_q == n_re - 11'd1);
  assign sym_nxt  = {1'b0, sym_q} + 5'd1;
  assign sym_over = (sym_nxt > {1'b0, se_q});
  assign cfg_bad  = (nrb_q == 7'd0) || (nrb_q > 7'(MAX_RB)) ||
                    (alloc_end(nsc_q, nrb_q) > 12'(TOTAL_SC)) ||
                    (se_q < ss_q);

  re_sym_credit u_credit (
    .clk    (CLK_RE),
    .rst    (RST_RE),
    .clr    (credit_clr),
    .inc    (Sym_Ready),
    .dec    (last_rd),
    .credit (credit)
  );

  // FSM next-state and read-address generation.
  always_comb begin
    state_d    = state_q;
    nsc_d      = nsc_q;
    nrb_d      = nrb_q;
    ss_d       = ss_q;
    se_d       = se_q;
    sym_d      = sym_q;
    sc_d       = sc_q;
    idx_d      = idx_q;
    rd_en_d    = 1'b0;
    cfg_err_d  = 1'b0;
    credit_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          nsc_d      = N_sc;
          nrb_d      = N_rb;
          ss_d       = Sym_Start;
          se_d       = Sym_End;
          credit_clr = 1'b1;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cfg_bad) begin
          cfg_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          sym_d   = ss_q;
          state_d = ST_WAIT_SYM;
        end
      end
      ST_WAIT_SYM: begin
        if (credit != 4'd0) begin
          if (sym_q == ss_q) begin
            state_d = ST_READ_DMRS;
            rd_en_d = 1'b1;
            sc_d    = nsc_q;
            idx_d   = 11'd0;
          end else if (sym_q > ss_q) begin
            state_d = ST_READ_DATA;
            rd_en_d = 1'b1;
            sc_d    = nsc_q;
            idx_d   = 11'd0;
          end
        end
      end
      ST_READ_DMRS, ST_READ_DATA: begin
        if (last_rd) begin
          sym_d   = sym_nxt[3:0];
          state_d = sym_over ? ST_IDLE : ST_WAIT_SYM;
        end else begin
          rd_en_d = 1'b1;
          idx_d   = idx_q + 11'd1;
          sc_d    = sc_q + (is_dmrs ? 11'd2 : 11'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tags that travel with each read so they line up with the returned sample.
  always_comb begin
    dmrs_v_d     = rd_en_q && is_dmrs;
    data_v_d     = rd_en_q && !is_dmrs;
    out_idx_d    = rd_en_q ? idx_q : 11'd0;
    out_sym_d    = (rd_en_q && !is_dmrs) ? sym_q : 4'd0;
    sym_done_d   = last_rd;
    demap_done_d = last_rd && sym_over;
  end

  // State, configuration and pipeline registers.
  always_ff @(posedge CLK_RE or posedge RST_RE) begin
    if (RST_RE) begin
      state_q      <= ST_IDLE;
      nsc_q        <= 11'd0;
      nrb_q        <= 7'd0;
      ss_q         <= 4'd0;
      se_q         <= 4'd0;
      sym_q        <= 4'd0;
      sc_q         <= 11'd0;
      idx_q        <= 11'd0;
      rd_en_q      <= 1'b0;
      cfg_err_q    <= 1'b0;
      dmrs_v_q     <= 1'b0;
      data_v_q     <= 1'b0;
      out_idx_q    <= 11'd0;
      out_sym_q    <= 4'd0;
      sym_done_q   <= 1'b0;
      demap_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nsc_q        <= nsc_d;
      nrb_q        <= nrb_d;
      ss_q         <= ss_d;
      se_q         <= se_d;
      sym_q        <= sym_d;
      sc_q         <= sc_d;
      idx_q        <= idx_d;
      rd_en_q      <= rd_en_d;
      cfg_err_q    <= cfg_err_d;
      dmrs_v_q     <= dmrs_v_d;
      data_v_q     <= data_v_d;
      out_idx_q    <= out_idx_d;
      out_sym_q    <= out_sym_d;
      sym_done_q   <= sym_done_d;
      demap_done_q <= demap_done_d;
    end
  end

  assign Grid_Rd_En   = rd_en_q;
  assign Grid_Rd_Addr = rd_en_q ? {sym_q, sc_q} : 15'd0;

  assign Dmrs_Valid = dmrs_v_q;
  assign Dmrs_I     = dmrs_v_q ? Grid_I : '0;
  assign Dmrs_Q     = dmrs_v_q ? Grid_Q : '0;
  assign Dmrs_Addr  = dmrs_v_q ? out_idx_q[9:0] : 10'd0;

  assign Data_Valid = data_v_q;
  assign Data_I     = data_v_q ? Grid_I : '0;
  assign Data_Q     = data_v_q ? Grid_Q : '0;
  assign Data_Addr  = data_v_q ? out_idx_q : 11'd0;
  assign Data_Sym   = data_v_q ? out_sym_q : 4'd0;

  assign Sym_Done   = sym_done_q;
  assign Demap_Done = demap_done_q;
  assign Cfg_Err    = cfg_err_q;

  assign dbg_state  = state_q;
  assign dbg_credit = credit;

endmodule

// File: doc/re_demapper.md
RE_DEMAPPER -- requirements
Module: re_demapper

Interface
REQ-001 SHALL have parameter DATA_W, default 18: width of each I/Q sample read from the grid and sent out.
REQ-002 SHALL have parameter TOTAL_SC, default 1200: subcarriers per symbol row in the grid memory.
REQ-003 CLK_RE  in  1  sole clock; all logic on its rising edge.
REQ-004 RST_RE  in  1  reset, asynchronous and active-high.
REQ-005 Start  in  1  one-cycle pulse; latches N_sc, N_rb, Sym_Start and Sym_End; clears the credit counter.
REQ-006 N_sc  in  11  first allocated subcarrier. N_rb  in  7  number of RBs allocated.
REQ-007 Sym_Start  in  4  DMRS symbol index. Sym_End  in  4  last data symbol index.
REQ-008 Sym_Ready  in  1  one-cycle pulse, one per grid symbol completely written by the upstream mapper.
REQ-009 Grid_Rd_En  out  1  grid memory read strobe.
REQ-010 Grid_Rd_Addr  out  15  read address, {symbol[3:0], subcarrier[10:0]}.
REQ-011 Grid_I, Grid_Q  in  DATA_W (signed)  read data, valid exactly 1 cycle after Grid_Rd_En.
REQ-012 Dmrs_I, Dmrs_Q  out  DATA_W; Dmrs_Valid  out  1; Dmrs_Addr  out  10  DMRS RE index, 0..6*N_rb-1.
REQ-013 Data_I, Data_Q  out  DATA_W; Data_Valid  out  1; Data_Addr  out  11  RE index within the symbol, 0..12*N_rb-1; Data_Sym  out  4  absolute symbol index.
REQ-014 Sym_Done, Demap_Done, Cfg_Err  out  1 each  one-cycle status pulses.

Function
REQ-015 FSM states SHALL be: IDLE, CHECK, WAIT_SYM, READ_DMRS, READ_DATA.
REQ-016 IDLE -> CHECK on Start. Start SHALL be ignored in every state other than IDLE.
REQ-017 CHECK SHALL pulse Cfg_Err and return to IDLE when any of these hold:
- N_rb == 0
- N_rb > 100
- N_sc + 12*N_rb > TOTAL_SC (computed in 12 bits)
- Sym_End < Sym_Start
Otherwise CHECK -> WAIT_SYM.
REQ-018 A 4-bit credit counter SHALL:
- increment on each Sym_Ready, saturating at 15;
- decrement at the last read of each symbol;
- stay unchanged when increment and decrement occur in the same cycle.
REQ-019 WAIT_SYM SHALL go to READ_DMRS when credit > 0 and current symbol == Sym_Start, to READ_DATA when credit > 0 and current symbol > Sym_Start, and otherwise remain in WAIT_SYM.
REQ-020 READ_DMRS SHALL issue one read per cycle at subcarriers N_sc, N_sc+2, ..., N_sc+12*N_rb-2 (6*N_rb reads); odd-offset REs SHALL NOT be read.
REQ-021 READ_DATA SHALL issue one read per cycle at subcarriers N_sc .. N_sc+12*N_rb-1 (12*N_rb reads).
REQ-022 Gaps in reading: none within a symbol; at least 1 idle cycle between symbols (WAIT_SYM).
REQ-023 Dmrs_Valid / Data_Valid SHALL equal Grid_Rd_En delayed 1 cycle, with Dmrs_Addr, Data_Addr and Data_Sym pipelined alongside so they align with the returned data.
REQ-024 Sym_Done SHALL pulse in the cycle of the last output valid of each symbol.
REQ-025 After the last read of a symbol, the current symbol SHALL increment; if the new value > Sym_End the FSM -> IDLE, else -> WAIT_SYM.
REQ-026 Demap_Done SHALL pulse together with the final Sym_Done, i.e. the DMRS one when Sym_End == Sym_Start.
REQ-027 Outputs not valid SHALL be driven to 0.
REQ-028 Subcarrier address arithmetic SHALL be 11-bit and never exceed TOTAL_SC-1, guaranteed by REQ-017.

Reset
REQ-029 While RST_RE is high, all of the following SHALL be 0 and the FSM SHALL be in IDLE: outputs, credit, counters, pipeline registers.
REQ-030 Reset mid-symbol SHALL discard the in-flight read; no valid pulse SHALL follow release.

Structure
REQ-031 FSM state encodings, TOTAL_SC, the 100-RB limit and the 12/6 RE-per-RB constants SHALL live in the shared PUSCH package.
REQ-032 The credit counter SHALL be a sub-module, re_sym_credit.

Verification
REQ-033 N_sc=0, N_rb=1, Sym_Start=2, Sym_End=3, two Sym_Ready pulses -> expected response:
- 6 DMRS reads at subcarriers 0,2,..,10 of symbol 2;
- 12 data reads at subcarriers 0..11 of symbol 3;
- 2 Sym_Done pulses and 1 Demap_Done.
REQ-034 N_sc=1100, N_rb=9 -> Cfg_Err pulse, no Grid_Rd_En.
REQ-035 Start with no Sym_Ready -> expected response:
- FSM holds in WAIT_SYM, no Grid_Rd_En;
- a Sym_Ready 50 cycles later starts reads 1-2 cycles after it.
REQ-036 Sym_Ready coincident with the last read of a symbol -> credit unchanged, next symbol read with no stall beyond the WAIT_SYM cycle.
REQ-037 N_sc=5, N_rb=2, Sym_Start=Sym_End=0 -> 12 DMRS outputs with Dmrs_Addr 0..11, Demap_Done on the 12th.
REQ-038 RST_RE asserted on the 4th data read -> all outputs 0 immediately, then idle until the next Start.
